obstacle_guard: RTL and testbench

- Consumes raw ultrasonic distance samples from the sonar front end and produces a filtered, debounced stop request for the car's motor controller.
- Applies a 3-tap median filter, N-sample confirmation, and stop/clear hysteresis.
- Forces a fail-safe stop when measurements stop arriving.
- Sits between the sonar distance counter and the motor/steering FSM; all logic runs on the 100 MHz system clock.

---
 rtl/obstacle_guard_if.sv | 31 +++
 rtl/obstacle_guard.sv | 210 +++++++++++++++++++++
 tb/tb_obstacle_guard.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/obstacle_guard_if.sv
// Sonar-to-motor obstacle path: raw distance samples in, filtered distance and stop/warn/fault out.
// master = sample producer / result consumer, slave = the guard itself.
interface obstacle_guard_if;
    logic [19:0] dist_in;
    logic        dist_valid;
    logic [19:0] dist_filt;
    logic        filt_valid;
    logic        stop;
    logic        warn;
    logic        sensor_fault;

    modport master (
        output dist_in,
        output dist_valid,
        input  dist_filt,
        input  filt_valid,
        input  stop,
        input  warn,
        input  sensor_fault
    );

    modport slave (
        input  dist_in,
        input  dist_valid,
        output dist_filt,
        output filt_valid,
        output stop,
        output warn,
        output sensor_fault
    );
endinterface

// File: rtl/obstacle_guard.sv
// Median-filtered, N-sample-confirmed stop request with hysteresis and a missing-sample fail-safe.
// Latency: sample -> dist_filt/warn 1 cycle, -> stop/sensor_fault 2 cycles; no backpressure (pulse in, pulse out).
module obstacle_guard #(
    parameter int unsigned STOP_TH     = 4000,
    parameter int unsigned CLEAR_TH    = 5000,
    parameter int unsigned WARN_TH     = 8000,
    parameter int unsigned N_CONFIRM   = 3,
    parameter int unsigned TIMEOUT_CYC = 30_000_000
) (
    input  logic              clk,
    input  logic              rst,
    obstacle_guard_if.slave   bus
);

    localparam int TW_RAW = $clog2(TIMEOUT_CYC + 1);
    localparam int TW     = (TW_RAW > 25) ? TW_RAW : 25;

    localparam logic [19:0]   FAR_DIST   = 20'hFFFFF;
    localparam logic [19:0]   STOP_TH_W  = 20'(STOP_TH);
    localparam logic [19:0]   CLEAR_TH_W = 20'(CLEAR_TH);
    localparam logic [19:0]   WARN_TH_W  = 20'(WARN_TH);
    localparam logic [3:0]    CNT_LAST   = 4'(N_CONFIRM - 1);
    localparam logic [TW-1:0] TMO_W      = TW'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_STOP  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [19:0]   s0_q, s0_d;
    logic [19:0]   s1_q, s1_d;
    logic [19:0]   s2_q, s2_d;
    logic          shifted_q, shifted_d;
    logic [19:0]   dist_filt_q, dist_filt_d;
    logic          filt_valid_q, filt_valid_d;
    logic          warn_q, warn_d;

    logic          accepted;
    logic          timeout_hit;
    logic [19:0]   median;

    function automatic logic [19:0] median3(input logic [19:0] a,
                                            input logic [19:0] b,
                                            input logic [19:0] c);
        logic [19:0] lo;
        logic [19:0] hi;
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
        if (c >= hi)      return hi;
        else if (c <= lo) return lo;
        else              return c;
    endfunction

    // A zero reading is a front-end glitch: it neither shifts the buffer nor feeds the watchdog.
    assign accepted    = bus.dist_valid && (bus.dist_in != 20'd0);
    assign timeout_hit = (timer_q == TMO_W);
    assign median      = median3(s0_q, s1_q, s2_q);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. Fault entry outranks a same-cycle evaluation;
    // a sample arriving on the expiry edge keeps the watchdog from firing.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_FAULT: begin
                if (accepted) begin
                    state_d = ST_STOP;
                    cnt_d   = 4'd0;
                end
            end
            ST_CLEAR: begin
                if (timeout_hit && !accepted) begin
                    state_d = ST_FAULT;
                    cnt_d   = 4'd0;
                end else if (filt_valid_q) begin
                    if (dist_filt_q < STOP_TH_W) begin
                        if (cnt_q == CNT_LAST) begin
                            state_d = ST_STOP;
                            cnt_d   = 4'd0;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else begin
                        cnt_d = 4'd0;
                    end
                end
            end
            ST_STOP: begin
                if (timeout_hit && !accepted) begin
                    state_d = ST_FAULT;
                    cnt_d   = 4'd0;
                end else if (filt_valid_q) begin
                    if (dist_filt_q >= CLEAR_TH_W) begin
                        if (cnt_q == CNT_LAST) begin
                            state_d = ST_CLEAR;
                            cnt_d   = 4'd0;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else begin
                        cnt_d = 4'd0;
                    end
                end
            end
            default: begin
                state_d = ST_FAULT;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (from registered state, so reset clears stop at once)
    // ------------------------------------------------------------------
    always_comb begin
        bus.stop         = 1'b0;
        bus.sensor_fault = 1'b0;
        case (state_q)
            ST_STOP:  bus.stop = 1'b1;
            ST_FAULT: begin
                bus.stop         = 1'b1;
                bus.sensor_fault = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: sample buffer, median stage, warn, watchdog timer
    // ------------------------------------------------------------------
    always_comb begin
        s0_d         = s0_q;
        s1_d         = s1_q;
        s2_d         = s2_q;
        shifted_d    = accepted;
        dist_filt_d  = dist_filt_q;
        filt_valid_d = shifted_q;
        warn_d       = warn_q;
        timer_d      = timer_q;

        if (accepted) begin
            s2_d = s1_q;
            s1_d = s0_q;
            s0_d = bus.dist_in;
        end

        if (shifted_q) begin
            dist_filt_d = median;
        end

        // warn follows the newest median but is held low whenever the guard is (or is becoming) faulted.
        if (state_d == ST_FAULT) begin
            warn_d = 1'b0;
        end else if (shifted_q) begin
            warn_d = (median < WARN_TH_W);
        end

        if (accepted) begin
            timer_d = '0;
        end else if (!timeout_hit) begin
            timer_d = timer_q + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_q         <= FAR_DIST;
            s1_q         <= FAR_DIST;
            s2_q         <= FAR_DIST;
            shifted_q    <= 1'b0;
            dist_filt_q  <= FAR_DIST;
            filt_valid_q <= 1'b0;
            warn_q       <= 1'b0;
            timer_q      <= '0;
        end else begin
            s0_q         <= s0_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            shifted_q    <= shifted_d;
            dist_filt_q  <= dist_filt_d;
            filt_valid_q <= filt_valid_d;
            warn_q       <= warn_d;
            timer_q      <= timer_d;
        end
    end

    assign bus.dist_filt  = dist_filt_q;
    assign bus.filt_valid = filt_valid_q;
    assign bus.warn       = warn_q;

endmodule

// File: tb/tb_obstacle_guard.sv
// Scoreboarded bench for obstacle_guard: directed scenarios plus randomized sample streams
// checked against a median/hysteresis reference model.
module tb_obstacle_guard;

    localparam int unsigned STOP_TH   = 4000;
    localparam int unsigned CLEAR_TH  = 5000;
    localparam int unsigned WARN_TH   = 8000;
    localparam int unsigned N_CONFIRM = 3;
    localparam int unsigned TMO       = 1000;
    localparam int unsigned FAR       = 20'hFFFFF;

    localparam int M_CLEAR = 0;
    localparam int M_STOP  = 1;
    localparam int M_FAULT = 2;

    typedef struct {
        int unsigned filt;
        bit          warn;
        bit          stop;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    obstacle_guard_if bus ();

    obstacle_guard #(
        .STOP_TH     (STOP_TH),
        .CLEAR_TH    (CLEAR_TH),
        .WARN_TH     (WARN_TH),
        .N_CONFIRM   (N_CONFIRM),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int unsigned m_buf[3];
    int          m_state;
    int          m_cnt;

    task automatic check(input string name, input int unsigned act, input int unsigned req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int unsigned med3(input int unsigned a, input int unsigned b, input int unsigned c);
        int unsigned q[$];
        q = '{a, b, c};
        q.sort();
        return q[1];
    endfunction

    task automatic model_reset();
        m_buf   = '{FAR, FAR, FAR};
        m_state = M_CLEAR;
        m_cnt   = 0;
        exp_q.delete();
    endtask

    // Reference behaviour for one accepted sample: re-entry from fault, median, hysteresis count.
    task automatic model_accept(input int unsigned v);
        exp_t        e;
        int unsigned m;
        if (m_state == M_FAULT) begin
            m_state = M_STOP;
            m_cnt   = 0;
        end
        m_buf[2] = m_buf[1];
        m_buf[1] = m_buf[0];
        m_buf[0] = v;
        m = med3(m_buf[0], m_buf[1], m_buf[2]);
        if (m_state == M_CLEAR) begin
            if (m < STOP_TH) begin
                m_cnt++;
                if (m_cnt == N_CONFIRM) begin m_state = M_STOP; m_cnt = 0; end
            end else m_cnt = 0;
        end else begin
            if (m >= CLEAR_TH) begin
                m_cnt++;
                if (m_cnt == N_CONFIRM) begin m_state = M_CLEAR; m_cnt = 0; end
            end else m_cnt = 0;
        end
        e.filt = m;
        e.warn = (m < WARN_TH);
        e.stop = (m_state != M_CLEAR);
        exp_q.push_back(e);
    endtask

    // Drives one dist_valid pulse; on return we sit at the negedge just after the sampling edge.
    task automatic send(input int unsigned v);
        bus.dist_in    = 20'(v);
        bus.dist_valid = 1'b1;
        @(negedge clk);
        bus.dist_valid = 1'b0;
        bus.dist_in    = 20'($urandom);
        if (v != 0) model_accept(v);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dist_filt"}, bus.dist_filt, FAR);
        check({tag, "_filt_valid"}, bus.filt_valid, 0);
        check({tag, "_stop"}, bus.stop, 0);
        check({tag, "_warn"}, bus.warn, 0);
        check({tag, "_sensor_fault"}, bus.sensor_fault, 0);
    endtask

    // Asynchronous reset pulse launched mid-cycle; outputs checked before any clock edge.
    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1 check_reset_outputs(tag);
        model_reset();
        idle(2);
        rst = 1'b0;
        idle(1);
    endtask

    // Monitor: pops one expectation per filt_valid, then checks stop on the following cycle.
    initial begin : monitor
        exp_t e;
        bit   pend;
        bit   pstop;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 1'b0;
                continue;
            end
            if (pend) begin
                check("stop_after_eval", bus.stop, pstop);
                pend = 1'b0;
            end
            if (bus.filt_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_filt_valid: got filt_valid=1 dist_filt=%0d, expected no output (t=%0t)",
                             bus.dist_filt, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("dist_filt", bus.dist_filt, e.filt);
                    check("warn", bus.warn, e.warn);
                    pend  = 1'b1;
                    pstop = e.stop;
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

    initial begin : stimulus
        int unsigned level;
        int unsigned v;
        int          r;
        int          waited;

        rst            = 1'b1;
        bus.dist_valid = 1'b0;
        bus.dist_in    = 20'd0;
        model_reset();
        idle(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        idle(2);

        // Four near samples from reset: first median is still far, stop exactly 2 cycles after the 4th.
        for (int i = 0; i < 3; i++) begin
            send(3000);
            idle(20);
        end
        send(3000);
        check("stop_t0", bus.stop, 0);
        idle(1);
        check("stop_t1", bus.stop, 0);
        idle(1);
        check("stop_t2", bus.stop, 1);
        idle(10);

        // Steady 6000 with a single 3000 spike that the median must swallow.
        repeat (6) begin send(6000); idle(10); end
        send(3000); idle(10);
        repeat (3) begin send(6000); idle(10); end
        check("spike_stop", bus.stop, 0);
        check("spike_warn", bus.warn, 1);

        // Hysteresis band keeps stop; 5000 x4 releases it.
        repeat (4) begin send(3000); idle(5); end
        repeat (10) begin send(4500); idle(5); end
        check("band_stop", bus.stop, 1);
        repeat (3) begin send(5000); idle(5); end
        check("clear_after_3", bus.stop, 1);
        send(5000); idle(2);
        check("clear_after_4", bus.stop, 0);
        idle(5);

        // Count reset by a near run interrupting the far run.
        repeat (4) begin send(3000); idle(5); end
        send(5000); idle(5);
        send(5000); idle(5);
        send(4500); idle(5);
        send(4500); idle(5);
        repeat (3) begin send(5000); idle(5); end
        check("count_reset_stop", bus.stop, 1);
        send(5000); idle(5);
        check("count_reset_clear", bus.stop, 0);

        // Randomized streams around the thresholds, with glitches and far spikes.
        level = 6000;
        for (int i = 0; i < 300; i++) begin
            if (i % 8 == 0) level = $urandom_range(2000, 10000);
            r = $urandom_range(0, 99);
            if (r < 8)       v = 0;
            else if (r < 13) v = $urandom_range(1, 1034482);
            else             v = level + $urandom_range(0, 1000) - 500;
            send(v);
            idle($urandom_range(0, 15));
        end
        idle(5);

        // Sample landing on the expiry edge wins over the watchdog.
        send(6000);
        idle(TMO);
        send(6000);
        check("expiry_edge_no_fault", bus.sensor_fault, 0);
        repeat (3) begin send(6000); idle(5); end
        check("pre_timeout_warn", bus.warn, 1);

        // Silence: fault exactly TMO+1 cycles after the last accepted edge.
        send(6000);
        idle(TMO);
        check("fault_at_tmo", bus.sensor_fault, 0);
        check("stop_at_tmo", bus.stop, 0);
        idle(1);
        check("fault_at_tmo1", bus.sensor_fault, 1);
        check("fault_stop", bus.stop, 1);
        check("fault_warn", bus.warn, 0);
        m_state = M_FAULT;
        m_cnt   = 0;
        idle(20);
        check("fault_held", bus.sensor_fault, 1);

        // Re-entry lands in STOP and needs fresh far confirmations.
        send(9000);
        check("reentry_fault", bus.sensor_fault, 0);
        check("reentry_stop", bus.stop, 1);
        repeat (4) begin send(9000); idle(5); end
        check("reentry_clear", bus.stop, 0);

        // Only zero readings: no filter output, fault still fires on time.
        send(9000);
        for (int k = 1; k <= 2 * TMO; k++) begin
            bus.dist_in    = 20'd0;
            bus.dist_valid = 1'b1;
            @(negedge clk);
            if (k == TMO)     check("zero_fault_at_tmo", bus.sensor_fault, 0);
            if (k == TMO + 1) begin
                check("zero_fault_at_tmo1", bus.sensor_fault, 1);
                m_state = M_FAULT;
                m_cnt   = 0;
            end
        end
        bus.dist_valid = 1'b0;
        send(2000);
        idle(10);

        // Reset mid-count, then four near samples are needed again.
        async_reset("midrst");
        repeat (3) begin send(3000); idle(5); end
        check("precount_warn", bus.warn, 1);
        check("precount_stop", bus.stop, 0);
        async_reset("cnt2rst");
        repeat (3) begin send(3000); idle(5); end
        check("after_rst_3near", bus.stop, 0);
        send(3000); idle(5);
        check("after_rst_4near", bus.stop, 1);
        async_reset("stoprst");

        waited = 0;
        while (exp_q.size() != 0 && waited < 100) begin
            idle(1);
            waited++;
        end
        check("scoreboard_drained", exp_q.size(), 0);
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
